// File: rtl/c_deser_fd_v5_0_if.sv
// Word-side and bit-side signals of the serial deserializer.
// The deserializer sits on the slave modport; the bit source and word consumer sit on master.
interface c_deser_fd_v5_0_if #(
    parameter int C_WIDTH = 16
);
    logic               sdin;
    logic               sdin_valid;
    logic               sync;
    logic [C_WIDTH-1:0] q;
    logic               q_valid;
    logic               q_ready;
    logic               aligned;
    logic               overrun;
    logic               ovr_clr;

    modport master (
        output sdin, sdin_valid, sync, q_ready, ovr_clr,
        input  q, q_valid, aligned, overrun
    );

    modport slave (
        input  sdin, sdin_valid, sync, q_ready, ovr_clr,
        output q, q_valid, aligned, overrun
    );
endinterface

// File: rtl/c_deser_fd_v5_0.sv
// Serial-to-parallel receiver: frames on SYNC, assembles C_WIDTH-bit words and
// hands them out through a registered valid/ready stage with a sticky overrun flag.
module c_deser_fd_v5_0 #(
    parameter int C_WIDTH      = 16,
    parameter int C_SHIFT_TYPE = 0,
    parameter int C_HAS_CE     = 0,
    parameter int C_NEED_SYNC  = 1
) (
    input  logic CLK,
    input  logic SCLR_N,
    input  logic CE,
    c_deser_fd_v5_0_if.slave bus
);
    localparam int CW = (C_WIDTH > 1) ? $clog2(C_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(C_WIDTH - 1);

    logic               ce_i;
    logic               accept;
    logic               complete;
    logic               ovr_set;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      bit_idx;
    logic [C_WIDTH-1:0] sreg;
    logic [C_WIDTH-1:0] word;
    logic [C_WIDTH-1:0] q_r;
    logic               q_valid_r;
    logic               aligned_r;
    logic               overrun_r;

    assign ce_i     = (C_HAS_CE != 0) ? CE : 1'b1;
    // A SYNC bit is accepted even before alignment and always counts as bit 0.
    assign accept   = ce_i & bus.sdin_valid & (aligned_r | bus.sync);
    assign bit_idx  = bus.sync ? '0 : cnt;
    assign complete = accept & (bit_idx == LAST);
    assign ovr_set  = complete & q_valid_r & ~bus.q_ready;

    // Stale bits from an abandoned partial word are shifted out before the
    // next completion, so SYNC never needs to clear the shift register.
    generate
        if (C_WIDTH == 1) begin : g_w1
            assign word = bus.sdin;
        end else if (C_SHIFT_TYPE == 0) begin : g_lsb_first
            assign word = {bus.sdin, sreg[C_WIDTH-1:1]};
        end else begin : g_msb_first
            assign word = {sreg[C_WIDTH-2:0], bus.sdin};
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!SCLR_N) begin
            sreg      <= '0;
            cnt       <= '0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
            overrun_r <= 1'b0;
            aligned_r <= (C_NEED_SYNC == 0);
        end else if (ce_i) begin
            if (accept) begin
                sreg <= word;
                cnt  <= complete ? '0 : bit_idx + 1'b1;
                if (bus.sync)
                    aligned_r <= 1'b1;
            end

            if (complete) begin
                // A full holding register drops the new word; the counter still wraps.
                if (!q_valid_r || bus.q_ready) begin
                    q_r       <= word;
                    q_valid_r <= 1'b1;
                end
            end else if (q_valid_r && bus.q_ready) begin
                q_valid_r <= 1'b0;
            end

            overrun_r <= ovr_set | (overrun_r & ~bus.ovr_clr);
        end
    end

    assign bus.q       = q_r;
    assign bus.q_valid = q_valid_r;
    assign bus.aligned = aligned_r;
    assign bus.overrun = overrun_r;
endmodule

// File: tb/tb_c_deser_fd_v5_0.sv
// Directed bench for c_deser_fd_v5_0: LSB-first and MSB-first receivers share one
// bit stream and are checked every cycle against a bit-placement model.
module tb_c_deser_fd_v5_0;
    localparam int W = 8;

    logic clk = 1'b0;
    logic sclr_n, ce, sdin, sdin_valid, sync, q_ready, ovr_clr;
    logic chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    c_deser_fd_v5_0_if #(.C_WIDTH(W)) if0 ();
    c_deser_fd_v5_0_if #(.C_WIDTH(W)) if1 ();

    assign if0.sdin = sdin;  assign if0.sdin_valid = sdin_valid;  assign if0.sync = sync;
    assign if0.q_ready = q_ready;  assign if0.ovr_clr = ovr_clr;
    assign if1.sdin = sdin;  assign if1.sdin_valid = sdin_valid;  assign if1.sync = sync;
    assign if1.q_ready = q_ready;  assign if1.ovr_clr = ovr_clr;

    c_deser_fd_v5_0 #(.C_WIDTH(W), .C_SHIFT_TYPE(0), .C_HAS_CE(1), .C_NEED_SYNC(1)) dut0 (
        .CLK(clk), .SCLR_N(sclr_n), .CE(ce), .bus(if0)
    );
    c_deser_fd_v5_0 #(.C_WIDTH(W), .C_SHIFT_TYPE(1), .C_HAS_CE(1), .C_NEED_SYNC(1)) dut1 (
        .CLK(clk), .SCLR_N(sclr_n), .CE(ce), .bus(if1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: index k=0 places bit n of a word at position n, k=1 at position W-1-n.
    logic [W-1:0] m_q [2];
    logic [W-1:0] m_acc [2];
    logic         m_qv [2];
    logic         m_al [2];
    logic         m_ovr [2];
    int           m_idx [2];
    logic         mset;
    int           mpos;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!sclr_n) begin
                m_q[k] = '0; m_acc[k] = '0; m_qv[k] = 1'b0;
                m_al[k] = 1'b0; m_ovr[k] = 1'b0; m_idx[k] = 0;
            end else if (ce) begin
                mset = 1'b0;
                if (sdin_valid && (m_al[k] || sync)) begin
                    if (sync) begin
                        m_idx[k] = 0;
                        m_al[k]  = 1'b1;
                    end
                    mpos = (k == 0) ? m_idx[k] : W - 1 - m_idx[k];
                    m_acc[k][mpos] = sdin;
                    if (m_idx[k] == W - 1) begin
                        m_idx[k] = 0;
                        if (!m_qv[k] || q_ready) begin
                            m_q[k]  = m_acc[k];
                            m_qv[k] = 1'b1;
                        end else begin
                            mset = 1'b1;
                        end
                    end else begin
                        m_idx[k] = m_idx[k] + 1;
                        if (m_qv[k] && q_ready) m_qv[k] = 1'b0;
                    end
                end else if (m_qv[k] && q_ready) begin
                    m_qv[k] = 1'b0;
                end
                m_ovr[k] = mset | (m_ovr[k] & ~ovr_clr);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("q0",  if0.q,       m_q[0]);
            chk("qv0", if0.q_valid, m_qv[0]);
            chk("al0", if0.aligned, m_al[0]);
            chk("ov0", if0.overrun, m_ovr[0]);
            chk("q1",  if1.q,       m_q[1]);
            chk("qv1", if1.q_valid, m_qv[1]);
            chk("al1", if1.aligned, m_al[1]);
            chk("ov1", if1.overrun, m_ovr[1]);
        end
    end

    task automatic step(input logic v, input logic b, input logic s);
        sdin_valid = v; sdin = b; sync = s;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic with_sync);
        for (int i = 0; i < W; i++) step(1'b1, w[i], (i == 0) && with_sync);
    endtask

    logic [W-1:0] got0 [$];
    logic [W-1:0] got1 [$];
    logic [W-1:0] wv;

    initial begin
        sclr_n = 1'b0; ce = 1'b1; sdin = 1'b0; sdin_valid = 1'b0;
        sync = 1'b0; q_ready = 1'b1; ovr_clr = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        chk("rst_q",   if0.q, 8'h00);
        chk("rst_qv",  if0.q_valid, 1'b0);
        chk("rst_al",  if0.aligned, 1'b0);
        chk("rst_ovr", if0.overrun, 1'b0);
        sclr_n = 1'b1;

        // Stream 1,1,0,1,1,0,0,0 with SYNC on the first bit
        wv = 8'h1B;
        step(1'b1, wv[0], 1'b1);
        chk("t1_al_first", if0.aligned, 1'b1);
        chk("t1_qv_early", if0.q_valid, 1'b0);
        for (int i = 1; i < W; i++) step(1'b1, wv[i], 1'b0);
        chk("t1_q_lsb", if0.q, 8'h1B);
        chk("t2_q_msb", if1.q, 8'hD8);
        chk("t1_qv",    if0.q_valid, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("t1_qv_one_cycle", if0.q_valid, 1'b0);

        // Unaligned bits are dropped until SYNC
        sclr_n = 1'b0; step(1'b0, 1'b0, 1'b0); sclr_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, i[0], 1'b0);
        chk("t3_al_before", if0.aligned, 1'b0);
        chk("t3_qv_before", if0.q_valid, 1'b0);
        send_word(8'h1B, 1'b1);
        chk("t3_q", if0.q, 8'h1B);
        step(1'b0, 1'b0, 1'b0);
        // SYNC mid-word discards the partial word
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
        send_word(8'hE4, 1'b1);
        chk("t3_resync_q0", if0.q, 8'hE4);
        chk("t3_resync_q1", if1.q, 8'h27);
        step(1'b0, 1'b0, 1'b0);

        // Overrun, and set-wins over OVR_CLR
        q_ready = 1'b0;
        send_word(8'h1B, 1'b1);
        chk("t4_qv", if0.q_valid, 1'b1);
        send_word(8'h55, 1'b0);
        chk("t4_q_held", if0.q, 8'h1B);
        chk("t4_ovr",    if0.overrun, 1'b1);
        wv = 8'h33;
        for (int i = 0; i < W - 1; i++) step(1'b1, wv[i], 1'b0);
        ovr_clr = 1'b1;
        step(1'b1, wv[W-1], 1'b0);
        ovr_clr = 1'b0;
        chk("t4_set_wins", if0.overrun, 1'b1);
        ovr_clr = 1'b1; step(1'b0, 1'b0, 1'b0); ovr_clr = 1'b0;
        chk("t4_ovr_clr", if0.overrun, 1'b0);
        chk("t4_q_still", if0.q, 8'h1B);
        q_ready = 1'b1; step(1'b0, 1'b0, 1'b0);
        chk("t4_consumed", if0.q_valid, 1'b0);

        // Gapped back-to-back words
        for (int n = 0; n < 2; n++) begin
            wv = (n == 0) ? 8'h1B : 8'hE4;
            for (int i = 0; i < W; i++) begin
                step(1'b1, wv[i], (n == 0) && (i == 0));
                if (if0.q_valid) got0.push_back(if0.q);
                if (if1.q_valid) got1.push_back(if1.q);
                step(1'b0, 1'b0, 1'b0);
                if (if0.q_valid) got0.push_back(if0.q);
                if (if1.q_valid) got1.push_back(if1.q);
            end
        end
        chk("t5_count0", got0.size(), 2);
        chk("t5_count1", got1.size(), 2);
        if (got0.size() == 2 && got1.size() == 2) begin
            chk("t5_w0_lsb", got0[0], 8'h1B);
            chk("t5_w1_lsb", got0[1], 8'hE4);
            chk("t5_w0_msb", got1[0], 8'hD8);
            chk("t5_w1_msb", got1[1], 8'h27);
        end
        chk("t5_no_ovr", if0.overrun, 1'b0);

        // CE=0 holds everything; reset overrides CE
        q_ready = 1'b0;
        send_word(8'h1B, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        ce = 1'b0; q_ready = 1'b1; ovr_clr = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        chk("t6_ce_hold_qv", if0.q_valid, 1'b1);
        chk("t6_ce_hold_q",  if0.q, 8'h1B);
        sclr_n = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        chk("t6_rst_q",   if0.q, 8'h00);
        chk("t6_rst_qv",  if0.q_valid, 1'b0);
        chk("t6_rst_ovr", if0.overrun, 1'b0);
        chk("t6_rst_al",  if0.aligned, 1'b0);
        sclr_n = 1'b1; ce = 1'b1; ovr_clr = 1'b0;
        send_word(8'h55, 1'b1);
        chk("t6_clean_q0", if0.q, 8'h55);
        chk("t6_clean_q1", if1.q, 8'hAA);
        step(1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
